// File: rtl/tl_inflight_limiter_if.sv
// tl_inflight_limiter_if: TileLink A-E channel bundle shared by host and device sides.
//   master modport: drives A/C/E requests and B/D ready, receives B/D and A/C/E ready.
//   slave  modport: the mirror image, as seen by the agent answering requests.
interface tl_inflight_limiter_if #(
   parameter int DataWidth   = 64,
   parameter int AddrWidth   = 56,
   parameter int SourceWidth = 1,
   parameter int SinkWidth   = 1
);
   localparam int MaskWidth = DataWidth / 8;

   logic                   a_valid;
   logic                   a_ready;
   logic [2:0]             a_opcode;
   logic [2:0]             a_param;
   logic [2:0]             a_size;
   logic [SourceWidth-1:0] a_source;
   logic [AddrWidth-1:0]   a_address;
   logic [MaskWidth-1:0]   a_mask;
   logic [DataWidth-1:0]   a_data;
   logic                   a_corrupt;

   logic                   b_valid;
   logic                   b_ready;
   logic [2:0]             b_opcode;
   logic [1:0]             b_param;
   logic [2:0]             b_size;
   logic [SourceWidth-1:0] b_source;
   logic [AddrWidth-1:0]   b_address;
   logic [MaskWidth-1:0]   b_mask;
   logic [DataWidth-1:0]   b_data;
   logic                   b_corrupt;

   logic                   c_valid;
   logic                   c_ready;
   logic [2:0]             c_opcode;
   logic [2:0]             c_param;
   logic [2:0]             c_size;
   logic [SourceWidth-1:0] c_source;
   logic [AddrWidth-1:0]   c_address;
   logic [DataWidth-1:0]   c_data;
   logic                   c_corrupt;

   logic                   d_valid;
   logic                   d_ready;
   logic [2:0]             d_opcode;
   logic [1:0]             d_param;
   logic [2:0]             d_size;
   logic [SourceWidth-1:0] d_source;
   logic [SinkWidth-1:0]   d_sink;
   logic                   d_denied;
   logic [DataWidth-1:0]   d_data;
   logic                   d_corrupt;

   logic                   e_valid;
   logic                   e_ready;
   logic [SinkWidth-1:0]   e_sink;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  a_ready,
      input  b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
      output b_ready,
      output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
      input  c_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
      output d_ready,
      output e_valid, e_sink,
      input  e_ready
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output a_ready,
      output b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
      input  b_ready,
      input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
      output c_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
      input  d_ready,
      input  e_valid, e_sink,
      output e_ready
   );
endinterface

// File: rtl/tl_inflight_limiter.sv
// tl_inflight_limiter: caps outstanding TileLink A requests at MaxInflight, counting per message.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   host          : upstream TileLink port (slave side of the host's bus)
//   dev           : downstream TileLink port toward the async FIFO (master side)
//   inflight_o    : registered count of outstanding request messages
//   err_o         : sticky protocol error (unmatched response or oversized message)
module tl_inflight_limiter #(
   parameter int DataWidth   = 64,
   parameter int AddrWidth   = 56,
   parameter int SourceWidth = 1,
   parameter int SinkWidth   = 1,
   parameter int MaxInflight = 4,
   parameter int MaxSize     = 6
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   tl_inflight_limiter_if.slave               host,
   tl_inflight_limiter_if.master              dev,
   output logic [$clog2(MaxInflight+1)-1:0]   inflight_o,
   output logic                               err_o
);
   localparam int Offset   = $clog2(DataWidth / 8);
   localparam int CntWidth = $clog2(MaxInflight + 1);

   typedef enum logic {FIRST, BURST} state_e;

   state_e              a_state, a_state_d, d_state, d_state_d;
   logic [7:0]          a_rem, a_rem_d, d_rem, d_rem_d;
   logic [7:0]          a_len, d_len;
   logic [CntWidth-1:0] cnt;
   logic                err;
   logic                full, a_open, a_fire, d_fire, a_last, d_last;
   logic                inc, dec, size_err;

   // Beats remaining after the first one; 8 bits covers size 7 on an 8-bit bus.
   function automatic logic [7:0] beats_m1(input logic has_data, input logic [2:0] size);
      beats_m1 = (has_data && int'(size) > Offset) ? (8'd1 << (int'(size) - Offset)) - 8'd1 : 8'd0;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_state <= FIRST;
         d_state <= FIRST;
         a_rem   <= '0;
         d_rem   <= '0;
      end else begin
         a_state <= a_state_d;
         d_state <= d_state_d;
         a_rem   <= a_rem_d;
         d_rem   <= d_rem_d;
      end
   end

   always_comb begin
      a_state_d = a_state;
      a_rem_d   = a_rem;
      d_state_d = d_state;
      d_rem_d   = d_rem;
      if (a_fire) begin
         a_state_d = (a_state == FIRST) ? ((a_len != 8'd0) ? BURST : FIRST) : (a_last ? FIRST : BURST);
         a_rem_d   = (a_state == FIRST) ? a_len : a_rem - 8'd1;
      end
      if (d_fire) begin
         d_state_d = (d_state == FIRST) ? ((d_len != 8'd0) ? BURST : FIRST) : (d_last ? FIRST : BURST);
         d_rem_d   = (d_state == FIRST) ? d_len : d_rem - 8'd1;
      end
   end

   // Gate only first beats, and only on the registered count, so dev_d_ready never reaches host_a_ready.
   always_comb begin
      full   = (cnt == CntWidth'(MaxInflight));
      a_open = (a_state == BURST) || !full;
      a_len  = beats_m1(host.a_opcode <= 3'd3, host.a_size);
      d_len  = beats_m1(dev.d_opcode == 3'd1 || dev.d_opcode == 3'd5, dev.d_size);
      a_fire = host.a_valid && dev.a_ready && a_open;
      d_fire = dev.d_valid && host.d_ready;
      a_last = (a_state == FIRST) ? (a_len == 8'd0) : (a_rem == 8'd1);
      d_last = (d_state == FIRST) ? (d_len == 8'd0) : (d_rem == 8'd1);
      inc    = a_fire && (a_state == FIRST);
      dec    = d_fire && d_last && (dev.d_opcode inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size_err = (a_fire && a_state == FIRST && int'(host.a_size) > MaxSize)
              || (d_fire && d_state == FIRST && int'(dev.d_size) > MaxSize);
   end

   // inc is only possible below full, so the count cannot overflow; underflow is flagged and clamped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (inc && !dec) cnt <= cnt + CntWidth'(1);
         else if (dec && !inc && cnt != '0) cnt <= cnt - CntWidth'(1);
         if ((dec && !inc && cnt == '0) || size_err) err <= 1'b1;
      end
   end

   assign inflight_o = cnt;
   assign err_o      = err;

   assign dev.a_valid   = host.a_valid && a_open;
   assign host.a_ready  = dev.a_ready && a_open;
   assign dev.a_opcode  = host.a_opcode;
   assign dev.a_param   = host.a_param;
   assign dev.a_size    = host.a_size;
   assign dev.a_source  = host.a_source;
   assign dev.a_address = host.a_address;
   assign dev.a_mask    = host.a_mask;
   assign dev.a_data    = host.a_data;
   assign dev.a_corrupt = host.a_corrupt;

   assign host.b_valid   = dev.b_valid;
   assign dev.b_ready    = host.b_ready;
   assign host.b_opcode  = dev.b_opcode;
   assign host.b_param   = dev.b_param;
   assign host.b_size    = dev.b_size;
   assign host.b_source  = dev.b_source;
   assign host.b_address = dev.b_address;
   assign host.b_mask    = dev.b_mask;
   assign host.b_data    = dev.b_data;
   assign host.b_corrupt = dev.b_corrupt;

   assign dev.c_valid   = host.c_valid;
   assign host.c_ready  = dev.c_ready;
   assign dev.c_opcode  = host.c_opcode;
   assign dev.c_param   = host.c_param;
   assign dev.c_size    = host.c_size;
   assign dev.c_source  = host.c_source;
   assign dev.c_address = host.c_address;
   assign dev.c_data    = host.c_data;
   assign dev.c_corrupt = host.c_corrupt;

   assign host.d_valid   = dev.d_valid;
   assign dev.d_ready    = host.d_ready;
   assign host.d_opcode  = dev.d_opcode;
   assign host.d_param   = dev.d_param;
   assign host.d_size    = dev.d_size;
   assign host.d_source  = dev.d_source;
   assign host.d_sink    = dev.d_sink;
   assign host.d_denied  = dev.d_denied;
   assign host.d_data    = dev.d_data;
   assign host.d_corrupt = dev.d_corrupt;

   assign dev.e_valid  = host.e_valid;
   assign host.e_ready = dev.e_ready;
   assign dev.e_sink   = host.e_sink;
endmodule

// File: tb/tb_tl_inflight_limiter.sv
// tb_tl_inflight_limiter: directed checks of the in-flight limiter with MaxInflight=4, DataWidth=64.
module tb_tl_inflight_limiter;
   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [2:0] inflight_o;
   logic       err_o;
   int         checks = 0;
   int         failures = 0;

   tl_inflight_limiter_if h_if ();
   tl_inflight_limiter_if d_if ();

   tl_inflight_limiter dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .host       (h_if),
      .dev        (d_if),
      .inflight_o (inflight_o),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic a_drv(input logic v, input logic [2:0] op, input logic [2:0] sz);
      h_if.a_valid  = v;
      h_if.a_opcode = op;
      h_if.a_size   = sz;
   endtask

   task automatic d_drv(input logic v, input logic [2:0] op, input logic [2:0] sz);
      d_if.d_valid  = v;
      d_if.d_opcode = op;
      d_if.d_size   = sz;
   endtask

   task automatic d_one(input logic [2:0] op, input logic [2:0] sz);
      @(negedge clk_i);
      d_drv(1'b1, op, sz);
      @(negedge clk_i);
      d_drv(1'b0, 3'd0, 3'd0);
      #1;
   endtask

   initial begin
      rst_ni = 1'b0;
      a_drv(1'b0, 3'd0, 3'd0);
      d_drv(1'b0, 3'd0, 3'd0);
      h_if.a_param = '0; h_if.a_source = '0; h_if.a_address = 56'h1000; h_if.a_mask = '1;
      h_if.a_data = 64'hA5A5_0000_1234_5678; h_if.a_corrupt = 1'b0;
      d_if.a_ready = 1'b1;
      d_if.b_valid = 1'b1; h_if.b_ready = 1'b1; d_if.b_opcode = 3'd6; d_if.b_param = '0; d_if.b_size = 3'd3;
      d_if.b_source = '0; d_if.b_address = 56'h0012_3456_789A; d_if.b_mask = '1; d_if.b_data = '0; d_if.b_corrupt = 1'b0;
      h_if.c_valid = 1'b0; d_if.c_ready = 1'b1; h_if.c_opcode = '0; h_if.c_param = '0; h_if.c_size = '0;
      h_if.c_source = '0; h_if.c_address = '0; h_if.c_data = 64'hDEAD_BEEF_CAFE_F00D; h_if.c_corrupt = 1'b0;
      h_if.d_ready = 1'b1; d_if.d_param = '0; d_if.d_source = '0; d_if.d_sink = '0; d_if.d_denied = 1'b0;
      d_if.d_data = 64'h0BAD_F00D_1122_3344; d_if.d_corrupt = 1'b0;
      h_if.e_valid = 1'b1; h_if.e_sink = 1'b1; d_if.e_ready = 1'b1;

      @(negedge clk_i);
      #1;
      chk("rst_cnt", 64'(inflight_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("pass_a_data", d_if.a_data, 64'hA5A5_0000_1234_5678);
      chk("pass_b_addr", 64'(h_if.b_address), 64'h0012_3456_789A);
      chk("pass_c_data", d_if.c_data, 64'hDEAD_BEEF_CAFE_F00D);
      chk("pass_d_data", h_if.d_data, 64'h0BAD_F00D_1122_3344);
      chk("pass_e", 64'({d_if.e_valid, d_if.e_sink}), 64'd3);
      chk("pass_d_ready", 64'(d_if.d_ready), 64'd1);
      rst_ni = 1'b1;

      // five back-to-back Gets; the fifth waits for a response
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         a_drv(1'b1, 3'd4, 3'd3);
         #1;
         chk("t1_rdy", 64'(h_if.a_ready), 64'd1);
         chk("t1_cnt", 64'(inflight_o), 64'(k));
      end
      @(negedge clk_i);
      #1;
      chk("t1_full_cnt", 64'(inflight_o), 64'd4);
      chk("t1_full_rdy", 64'(h_if.a_ready), 64'd0);
      chk("t1_full_vld", 64'(d_if.a_valid), 64'd0);
      @(negedge clk_i);
      #1;
      chk("t1_hold_rdy", 64'(h_if.a_ready), 64'd0);
      @(negedge clk_i);
      d_drv(1'b1, 3'd1, 3'd3);
      #1;
      chk("t1_d_vld", 64'(h_if.d_valid), 64'd1);
      chk("t1_d_same_rdy", 64'(h_if.a_ready), 64'd0);
      @(negedge clk_i);
      d_drv(1'b0, 3'd0, 3'd0);
      #1;
      chk("t1_after_d_cnt", 64'(inflight_o), 64'd3);
      chk("t1_after_d_rdy", 64'(h_if.a_ready), 64'd1);
      @(negedge clk_i);
      a_drv(1'b0, 3'd0, 3'd0);
      #1;
      chk("t1_fifth_cnt", 64'(inflight_o), 64'd4);

      // 8-beat AccessAckData: decrement only after the last beat
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         d_drv(1'b1, 3'd1, 3'd6);
         #1;
         chk("t3_cnt_mid", 64'(inflight_o), 64'd4);
      end
      @(negedge clk_i);
      d_drv(1'b0, 3'd0, 3'd0);
      #1;
      chk("t3_cnt_end", 64'(inflight_o), 64'd3);

      // 4-beat PutFullData from 3: later beats pass while full
      @(negedge clk_i);
      a_drv(1'b1, 3'd0, 3'd5);
      #1;
      chk("t2_b1_rdy", 64'(h_if.a_ready), 64'd1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk_i);
         #1;
         chk("t2_cnt", 64'(inflight_o), 64'd4);
         chk("t2_rdy", 64'(h_if.a_ready), 64'd1);
         chk("t2_vld", 64'(d_if.a_valid), 64'd1);
      end
      @(negedge clk_i);
      a_drv(1'b0, 3'd0, 3'd0);
      #1;
      chk("t2_post_cnt", 64'(inflight_o), 64'd4);
      chk("t2_post_rdy", 64'(h_if.a_ready), 64'd0);
      d_one(3'd0, 3'd0);
      chk("t2_ack_cnt", 64'(inflight_o), 64'd3);

      // simultaneous inc and dec at 2
      d_one(3'd0, 3'd0);
      chk("t4_pre_cnt", 64'(inflight_o), 64'd2);
      @(negedge clk_i);
      a_drv(1'b1, 3'd4, 3'd3);
      d_drv(1'b1, 3'd0, 3'd0);
      @(negedge clk_i);
      a_drv(1'b0, 3'd0, 3'd0);
      d_drv(1'b0, 3'd0, 3'd0);
      #1;
      chk("t4_cnt", 64'(inflight_o), 64'd2);

      // ReleaseAck never decrements; AccessAck at zero flags an error
      d_one(3'd0, 3'd0);
      chk("t5_pre_cnt", 64'(inflight_o), 64'd1);
      d_one(3'd6, 3'd0);
      chk("t5_rel_cnt", 64'(inflight_o), 64'd1);
      chk("t5_rel_err", 64'(err_o), 64'd0);
      d_one(3'd0, 3'd0);
      chk("t5_zero_cnt", 64'(inflight_o), 64'd0);
      chk("t5_zero_err", 64'(err_o), 64'd0);
      d_one(3'd0, 3'd0);
      chk("t5_under_cnt", 64'(inflight_o), 64'd0);
      chk("t5_under_err", 64'(err_o), 64'd1);
      @(negedge clk_i);
      #1;
      chk("t5_sticky_err", 64'(err_o), 64'd1);

      // reset after beat 2 of a 4-beat burst
      @(negedge clk_i);
      a_drv(1'b1, 3'd0, 3'd5);
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      chk("t6_mid_cnt", 64'(inflight_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_cnt", 64'(inflight_o), 64'd0);
      chk("t6_rst_err", 64'(err_o), 64'd0);
      a_drv(1'b0, 3'd0, 3'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      a_drv(1'b1, 3'd4, 3'd3);
      @(negedge clk_i);
      a_drv(1'b0, 3'd0, 3'd0);
      #1;
      chk("t6_new_cnt", 64'(inflight_o), 64'd1);

      // oversized message is forwarded but flagged
      @(negedge clk_i);
      a_drv(1'b1, 3'd4, 3'd7);
      #1;
      chk("t7_vld", 64'(d_if.a_valid), 64'd1);
      @(negedge clk_i);
      a_drv(1'b0, 3'd0, 3'd0);
      #1;
      chk("t7_cnt", 64'(inflight_o), 64'd2);
      chk("t7_err", 64'(err_o), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tl_inflight_limiter.md
Name: tl_inflight_limiter

Overview:
- Single-clock TileLink stage sitting directly upstream of tl_fifo_async on the host side.
- Caps the number of outstanding A-channel requests at MaxInflight so that the async crossing and the far-side device are never over-subscribed.
- Tracks multi-beat bursts on A and D so the count changes once per message, not once per beat.
- B, C and E channels pass straight through.

Parameters:
- DataWidth, 64, data bus width in bits (power of two, >= 8)
- AddrWidth, 56, address width
- SourceWidth, 1, source ID width
- SinkWidth, 1, sink ID width
- MaxInflight, 4, maximum outstanding request messages (>= 1)
- MaxSize, 6, largest supported log2 transfer size in bytes

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- host_a_valid / host_a_ready  in / out  1  A handshake from upstream host
- host_a_opcode  in  3  A opcode
- host_a_size  in  3  A log2 size
- host_a_source / address / mask / data / param / corrupt  in  widths per bundle  A payload
- dev_a_valid / dev_a_ready  out / in  1  A handshake toward the FIFO
- dev_a_*  out  same widths  A payload, combinational copy of host_a_*
- dev_d_valid / dev_d_ready  in / out  1  D handshake from the FIFO
- dev_d_opcode, dev_d_size, other dev_d_* payload  in  per bundle  D payload
- host_d_*  out / in  per bundle  D payload and handshake toward host, combinational copy of dev_d_*
- host_b_*, host_c_*, host_e_* and dev_b_*, dev_c_*, dev_e_*  mixed  per bundle  combinational pass-through
- inflight_o  out  $clog2(MaxInflight+1)  current outstanding count
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset values:
  - inflight_o = 0, err_o = 0.
  - A and D beat counters = 0.
  - Both channels in FIRST state.
  - All pass-through outputs follow their inputs.
- Beat count of a message:
  - Offset = log2(DataWidth/8).
  - beats = 2^(size - Offset) if the message carries data and size > Offset; otherwise beats = 1.
  - A-channel opcodes that carry data: 0, 1, 2, 3.
  - D-channel opcodes that carry data: 1 (AccessAckData), 5 (GrantData).
- A channel FSM (states FIRST, BURST):
  - In FIRST:
    - dev_a_valid = host_a_valid & !full, where full = (inflight == MaxInflight).
    - host_a_ready = dev_a_ready & !full.
    - On fire with beats > 1: load remaining = beats-1 and go to BURST.
  - In BURST:
    - Beats are never gated.
    - Each fire decrements remaining; return to FIRST when remaining reaches 0 on fire.
  - The gate uses the registered count only. No combinational path from dev_d_ready to host_a_ready.
- D channel FSM (states FIRST, BURST): beat tracking mirrors the A channel. D is never gated.
- Count update:
  - inc = A fire in FIRST.
  - dec = D fire on the last beat AND opcode in {0, 1, 2, 4, 5}.
  - ReleaseAck (6) never decrements.
  - inc & dec in the same cycle: count unchanged.
  - Count updates one cycle after fire.
  - A request accepted at count MaxInflight-1 makes full true on the next cycle.
- Error handling (the count never leaves its range):
  - dec when count == 0: set err_o, hold count at 0.
  - size > MaxSize on any first beat: set err_o; the message is still forwarded.
  - err_o clears only on reset.
- Reset asserted mid-burst: all state returns to reset values immediately (asynchronous). The upstream side is reset concurrently.
- Latency: zero-cycle combinational path on every channel. No buffering.

Test Plan:
- MaxInflight=4, five single-beat Get requests back-to-back, no D responses:
  - First four fire on cycles 0-3; inflight_o = 4 on cycle 4.
  - Fifth is held with host_a_ready = 0 until a D AccessAckData last beat fires.
  - It fires the cycle after that D beat.
- DataWidth=64, PutFullData size=5 (4 beats) started at inflight=3:
  - First beat raises count to 4.
  - Beats 2-4 fire unthrottled despite full.
  - A single-beat AccessAck returns count to 3.
- AccessAckData size=6 (8 beats) for an outstanding Get: count decrements only after the 8th beat fires, never earlier.
- A first beat and D last beat fire in the same cycle at inflight=2: inflight_o stays 2.
- D ReleaseAck at inflight=1: count stays 1, err_o stays 0. AccessAck at inflight=0: err_o = 1, count stays 0.
- Reset asserted during a 4-beat A burst after beat 2:
  - Outputs go to reset values immediately.
  - After release, a new single-beat Get is treated as a first beat and count reads 1.
